// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix output stage: default element width,
// index-width helper, streaming FSM state type and the ReLU helper used when
// MATRIX_STREAM_RELU_EN is defined.
package matrix_pkg;

    localparam int DEF_WIDTH_BIT = 32;

    // Counter width for an index range of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // Clamp negative values to zero. Operates on a 64-bit signed container so
    // any element width up to 64 can use it via sign-extending casts.
    function automatic logic signed [63:0] relu(input logic signed [63:0] x);
        return (x < 0) ? 64'sd0 : x;
    endfunction

endpackage

// File: rtl/matrix_stream_out.sv
// Matrix output stage: captures a full ROWS x COLS result matrix in one cycle
// and streams it row-major, one element per valid/ready transfer. A new matrix
// can be captured on the last-element transfer, so consecutive matrices stream
// without a bubble.
// Optional build macro: MATRIX_STREAM_RELU_EN (ReLU applied to out_data).
module matrix_stream_out
    import matrix_pkg::*;
#(
    parameter int ROWS      = 3,
    parameter int COLS      = 3,
    parameter int WIDTH_BIT = DEF_WIDTH_BIT
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic signed [ROWS-1:0][COLS-1:0][WIDTH_BIT-1:0] MatrixO,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [WIDTH_BIT-1:0]                  out_data,
    output logic [idx_w(ROWS)-1:0]                       out_row,
    output logic [idx_w(COLS)-1:0]                       out_col,
    output logic                                         out_last
);

    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    stream_state_t state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic signed [WIDTH_BIT-1:0] buf_q [ROWS][COLS];

    logic capture;
    logic xfer;
    logic signed [WIDTH_BIT-1:0] elem;

    assign out_valid = (state_q == STREAM);
    assign out_last  = (state_q == STREAM) && (row_q == ROW_LAST) && (col_q == COL_LAST);
    // Ready while idle, or when the final element leaves this very cycle.
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign capture   = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    assign out_row = row_q;
    assign out_col = col_q;
    assign elem    = buf_q[row_q][col_q];

`ifdef MATRIX_STREAM_RELU_EN
    assign out_data = WIDTH_BIT'(relu(64'(elem)));
`else
    assign out_data = elem;
`endif

    // Next state and row-major index advance; capture takes priority so the
    // counters restart at [0][0] on a back-to-back matrix.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (capture) begin
            state_d = STREAM;
            row_d   = '0;
            col_d   = '0;
        end else if (xfer) begin
            if (out_last) begin
                state_d = IDLE;
                row_d   = '0;
                col_d   = '0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // FSM and index registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Matrix buffer: written only on capture, so MatrixO may change afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    buf_q[r][c] <= MatrixO[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_out.sv
// Directed testbench for matrix_stream_out: capture, streaming order,
// backpressure, back-to-back matrices, ignored input, async reset mid-stream
// and signed / ReLU output.
module tb_matrix_stream_out;

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int W    = 32;

    logic clock = 1'b0;
    logic reset;
    logic in_valid;
    logic in_ready;
    logic signed [ROWS-1:0][COLS-1:0][W-1:0] MatrixO;
    logic out_valid;
    logic out_ready;
    logic signed [W-1:0] out_data;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic out_last;

    int checks   = 0;
    int failures = 0;
    int exp_q[9];

    int mat_a[9]   = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int mat_7[9]   = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    int mat_s[9]   = '{30, 24, 18, 84, -5, 54, 138, 114, 90};
    int mat_x[9]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int mat_s_exp[9];

    matrix_stream_out #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .WIDTH_BIT (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .MatrixO   (MatrixO),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_mat(input int v[9]);
        for (int i = 0; i < 9; i++) MatrixO[i / 3][i % 3] = v[i];
    endtask

    // Present a matrix while idle and let it be captured on the next edge;
    // MatrixO is then scrambled to show the buffer holds its own copy.
    task automatic capture(input int v[9], input string tag);
        load_mat(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) MatrixO[i / 3][i % 3] = 32'h0BAD_0000 + i;
        $display("capture %s", tag);
    endtask

    // Consume the 9 elements in exp_q.
    // bp:   out_ready follows 1,0,0,1 repeating.
    // mode: 0 in_valid low; 1 present nxt from element 6 through the last
    //       transfer (back-to-back); 2 pulse nxt at elements 3..4 (ignored).
    task automatic drain(input bit bp, input int mode, input int nxt[9]);
        int idx = 0;
        int k   = 0;
        while (idx < 9 && k < 64) begin
            out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (mode == 1 && idx >= 6) begin
                load_mat(nxt);
                in_valid = 1'b1;
            end else if (mode == 2 && (idx == 3 || idx == 4)) begin
                load_mat(nxt);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_q[idx]);
            check("out_row", out_row, idx / 3);
            check("out_col", out_col, idx % 3);
            check("out_last", out_last, (idx == 8));
            check("in_ready", in_ready, (idx == 8) && out_ready);
            if (out_ready) begin
                $display("xfer row=%0d col=%0d data=%0d last=%0d", out_row, out_col, out_data, out_last);
                idx++;
            end
            @(posedge clock);
            #1;
            k++;
        end
        if (idx < 9) check("drain_timeout", idx, 9);
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_idle_last"}, out_last, 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) mat_s_exp[i] = mat_s[i];
`ifdef MATRIX_STREAM_RELU_EN
        mat_s_exp[4] = 0;
`endif
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        MatrixO   = '0;

        // Reset state.
        @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic stream.
        exp_q = mat_a;
        capture(mat_a, "basic");
        drain(1'b0, 0, mat_x);
        check_idle("basic");

        // Backpressure.
        capture(mat_a, "bp");
        drain(1'b1, 0, mat_x);
        check_idle("bp");

        // Back-to-back: matrix of 7s follows 90 with no bubble.
        capture(mat_a, "b2b");
        drain(1'b0, 1, mat_7);
        exp_q = mat_7;
        drain(1'b1, 0, mat_x);
        check_idle("b2b");

        // Mid-stream in_valid pulse is ignored.
        exp_q = mat_a;
        capture(mat_a, "ign");
        drain(1'b0, 2, mat_x);
        check_idle("ign");

        // Asynchronous reset after element 69 has been transferred.
        capture(mat_a, "rstmid");
        out_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("rstmid_pre_data", out_data, 54);
        reset = 1'b1;
        #1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_out_last", out_last, 0);
        check("rstmid_in_ready", in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        $display("reset mid-stream released");

        // Signed element (-5), raw or ReLU depending on build.
        exp_q = mat_s_exp;
        capture(mat_s, "signed");
        drain(1'b0, 0, mat_x);
        check_idle("signed");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
